fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
//  Parametrised EX-stage operand forwarding plus hazard/stall control for the pipelined MIPS core.
//  - Picks each EX operand from one of four sources: register file, EX/MEM ALU result, MEM/WB
//    result, or MEM-stage load data.
//  - Detects load-use hazards and tracks a multi-cycle multiply/divide unit with a small FSM.
//  - Drives the IF/ID stall and ID/EX bubble controls.
// PARAMETERS
//  DATA_W   32  operand/data width
//  REG_AW   5   register address width; address 0 is hardwired zero
//  NUM_SRC  2   number of EX operands forwarded (rs, rt, ...)
//  MD_LAT   4   mult/div latency in cycles, >=2
// PORTS
//  clk           in   1                 clock; all state on rising edge
//  rst           in   1                 synchronous, active-high reset
//  id_src_addr   in   NUM_SRC*REG_AW    ID-stage source regs, src i at [i*REG_AW +: REG_AW]
//  id_src_use    in   NUM_SRC           ID instruction actually reads source i
//  id_md_use     in   1                 ID instruction reads HI/LO (mult/div result)
//  ex_src_addr   in   NUM_SRC*REG_AW    EX-stage source regs, same packing as id_src_addr
//  ex_rd         in   REG_AW            EX-stage destination reg
//  ex_memread    in   1                 EX-stage instruction is a load
//  mem_rd        in   REG_AW            EX/MEM destination reg
//  mem_regwrite  in   1                 EX/MEM writes a reg
//  mem_memread   in   1                 EX/MEM instruction is a load
//  wb_rd         in   REG_AW            MEM/WB destination reg
//  wb_regwrite   in   1                 MEM/WB writes a reg
//  reg_data      in   NUM_SRC*DATA_W    ID/EX register-file operands
//  exmem_alu     in   DATA_W            EX/MEM ALU result
//  memwb_res     in   DATA_W            MEM/WB write-back value
//  mem_dout      in   DATA_W            MEM-stage data-memory read data
//  md_start      in   1                 EX issues a mult/div this cycle
//  fwd_sel       out  NUM_SRC*2         per-source select: 0 reg, 1 exmem_alu, 2 memwb_res, 3 mem_dout
//  op_out        out  NUM_SRC*DATA_W    forwarded operands
//  stall         out  1                 hold PC and IF/ID
//  flush_ex      out  1                 insert bubble into ID/EX
//  md_busy       out  1                 mult/div in progress
//  md_done       out  1                 1-cycle pulse: HI/LO result valid
// BEHAVIOUR
//  - Forward select for source i is combinational; it is evaluated top-down and the first hit wins:
//    1. ex_src_addr[i]==0 -> 0 (register 0 is never forwarded)
//    2. mem_regwrite && mem_rd==src: mem_memread -> 3, else -> 1 (EX/MEM beats MEM/WB)
//    3. wb_regwrite && wb_rd==src -> 2
//    4. otherwise -> 0
//  - op_out[i] is a pure mux of the four inputs under fwd_sel[i]; no latency, no X on any select value.
//  - Load-use hazard is combinational:
//    lu_haz = ex_memread && ex_rd!=0 && any(id_src_use[i] && id_src_addr[i]==ex_rd).
//    The bubble clears it the next cycle, so a load-use always costs exactly 1 stall cycle. The
//    load then sits in MEM and the dependent op takes select 3.
//  - Mult/div FSM (registered):
//    - IDLE: md_start -> BUSY, cnt <= MD_LAT-1.
//    - BUSY: cnt decrements each cycle; at cnt==1 -> DONE; md_start while BUSY is ignored.
//    - DONE: md_done=1 for one cycle -> IDLE; md_start in DONE -> BUSY (back-to-back allowed).
//    - md_busy=1 in BUSY.
//    - md_haz = id_md_use && (state==BUSY || md_start). DONE does not stall, because the result is
//      available to the ID op then.
//  - stall = flush_ex = lu_haz | md_haz. Simultaneous hazards give one stall per cycle, no double count.
//  - Reset: state IDLE, cnt 0, md_busy/md_done/stall/flush_ex = 0; a reset mid-BUSY abandons the op.
//    fwd_sel/op_out follow their inputs combinationally, also during reset.
// CONFIGURATION
//  STALL_CNT_EN defined:
//   - Adds output stall_count (32 bits). It resets to 0 and increments on every cycle with stall=1.
//   - It saturates at 32'hFFFF_FFFF and also counts during BUSY stalls.
//  Undefined: the port and counter do not exist; all other behaviour is identical.
// TESTING
//  - Hazard-free forwarding:
//    - EX/MEM ALU hazard: mem_rd=8, mem_regwrite=1, ex_src0=8, exmem_alu=32'h1234 -> fwd_sel0=1, op_out0=32'h1234, stall=0.
//    - Priority: mem_rd=wb_rd=9, both regwrite, ex_src1=9 -> fwd_sel1=1, not 2.
//  - Register 0 guard: mem_rd=0, mem_regwrite=1, ex_src0=0, reg_data0=0 -> fwd_sel0=0, op_out0=0.
//  - Load-use: ex_memread=1, ex_rd=5, id_src0=5 used -> stall=flush_ex=1 for exactly 1 cycle.
//    Next cycle mem_memread=1, mem_rd=5, mem_dout=32'hCAFE -> fwd_sel0=3, op_out0=32'hCAFE.
//  - Mult/div, MD_LAT=4: md_start at cycle 0, id_md_use held high:
//    - md_busy for cycles 1-3, stall for cycles 0-3, md_done at cycle 4.
//    - A second md_start at cycle 2 is ignored.
//  - Reset mid-BUSY: assert rst at cycle 2 -> next cycle md_busy=0, stall=0, md_done never pulses.
//    With STALL_CNT_EN, stall_count=0 after reset and equals 4 after the mult/div scenario.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX-stage operand forwarding, load-use detection and a
// mult/div latency tracker driving the IF/ID stall and ID/EX bubble.
// Optional feature: define STALL_CNT_EN to add a saturating 32-bit stall_count
// output that counts every stalled cycle.
// md_state exposes the mult/div FSM state (0 idle, 1 busy, 2 done).
// Handshake: md_start is a single-cycle request that is accepted only in the
// idle or done states. md_done is a one-cycle pulse, and no backpressure exists.
module fwd_hazard_unit #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int MD_LAT  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_use,
  input  logic                      id_md_use,
  input  logic [NUM_SRC*REG_AW-1:0] ex_src_addr,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      ex_memread,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic                      mem_regwrite,
  input  logic                      mem_memread,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic                      wb_regwrite,
  input  logic [NUM_SRC*DATA_W-1:0] reg_data,
  input  logic [DATA_W-1:0]         exmem_alu,
  input  logic [DATA_W-1:0]         memwb_res,
  input  logic [DATA_W-1:0]         mem_dout,
  input  logic                      md_start,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic [NUM_SRC*DATA_W-1:0] op_out,
  output logic                      stall,
  output logic                      flush_ex,
  output logic                      md_busy,
  output logic                      md_done,
`ifdef STALL_CNT_EN
  output logic [31:0]               stall_count,
`endif
  output logic [1:0]                md_state
);

  localparam int CNT_W = $clog2(MD_LAT + 1);

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             lu_haz;
  logic             md_haz;

  // Per-source forward select (first hit wins) and operand mux.
  always_comb begin
    logic [REG_AW-1:0] src;
    logic [1:0]        sel;
    fwd_sel = '0;
    op_out  = '0;
    src     = '0;
    sel     = 2'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src = ex_src_addr[i*REG_AW +: REG_AW];
      if (src == '0)
        sel = 2'd0;
      else if (mem_regwrite && mem_rd == src)
        sel = mem_memread ? 2'd3 : 2'd1;
      else if (wb_regwrite && wb_rd == src)
        sel = 2'd2;
      else
        sel = 2'd0;
      fwd_sel[i*2 +: 2] = sel;
      case (sel)
        2'd0:    op_out[i*DATA_W +: DATA_W] = reg_data[i*DATA_W +: DATA_W];
        2'd1:    op_out[i*DATA_W +: DATA_W] = exmem_alu;
        2'd2:    op_out[i*DATA_W +: DATA_W] = memwb_res;
        default: op_out[i*DATA_W +: DATA_W] = mem_dout;
      endcase
    end
  end

  // Load-use: an ID source that is actually read matches a load's destination in EX.
  always_comb begin
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      if (id_src_use[i] && id_src_addr[i*REG_AW +: REG_AW] == ex_rd)
        hit = 1'b1;
    lu_haz = ex_memread && (ex_rd != '0) && hit;
  end

  // HI/LO reader waits while the unit is busy or being started; DONE already has the result.
  assign md_haz   = id_md_use && ((state == MD_BUSY) || md_start);
  assign stall    = !rst && (lu_haz || md_haz);
  assign flush_ex = stall;
  assign md_state = state;

  // Mult/div latency FSM with registered busy/done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      md_busy <= 1'b0;
      md_done <= 1'b0;
    end else begin
      md_busy <= 1'b0;
      md_done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (md_start) begin
            state   <= MD_BUSY;
            cnt     <= CNT_W'(MD_LAT - 1);
            md_busy <= 1'b1;
          end
        end
        MD_BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state   <= MD_DONE;
            md_done <= 1'b1;
          end else begin
            md_busy <= 1'b1;
          end
        end
        MD_DONE: begin
          if (md_start) begin
            state   <= MD_BUSY;
            cnt     <= CNT_W'(MD_LAT - 1);
            md_busy <= 1'b1;
          end else begin
            state <= MD_IDLE;
          end
        end
        default: begin
          state <= MD_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef STALL_CNT_EN
  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst)
      stall_count <= '0;
    else if (stall && stall_count != 32'hFFFF_FFFF)
      stall_count <= stall_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios plus random traffic, checked by
// a scoreboard fed from an independent reference model.
module tb_fwd_hazard_unit;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NS = 2;
  localparam int ML = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS*AW-1:0] id_src_addr, ex_src_addr;
  logic [NS-1:0]    id_src_use;
  logic             id_md_use, ex_memread, mem_regwrite, mem_memread, wb_regwrite, md_start;
  logic [AW-1:0]    ex_rd, mem_rd, wb_rd;
  logic [NS*DW-1:0] reg_data;
  logic [DW-1:0]    exmem_alu, memwb_res, mem_dout;
  logic [NS*2-1:0]  fwd_sel;
  logic [NS*DW-1:0] op_out;
  logic             stall, flush_ex, md_busy, md_done;
  logic [1:0]       md_state;
  logic [31:0]      stall_count;

  fwd_hazard_unit #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS), .MD_LAT(ML)) dut (
    .clk(clk), .rst(rst),
    .id_src_addr(id_src_addr), .id_src_use(id_src_use), .id_md_use(id_md_use),
    .ex_src_addr(ex_src_addr), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .reg_data(reg_data), .exmem_alu(exmem_alu), .memwb_res(memwb_res), .mem_dout(mem_dout),
    .md_start(md_start),
    .fwd_sel(fwd_sel), .op_out(op_out), .stall(stall), .flush_ex(flush_ex),
    .md_busy(md_busy), .md_done(md_done),
`ifdef STALL_CNT_EN
    .stall_count(stall_count),
`endif
    .md_state(md_state)
  );

`ifndef STALL_CNT_EN
  assign stall_count = 32'd0;
`endif

  // Clock
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NS*2-1:0]  sel;
    logic [NS*DW-1:0] op;
    logic             stall;
    logic             busy;
    logic             done;
    logic [31:0]      cnt;
    logic [15:0]      tag;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: the cycle number at which the current mult/div was
  // accepted (-1 if none) and the number of stalled cycles since reset.
  int          cyc = 0;
  int          md_start_cyc = -1;
  logic [31:0] m_cnt = 32'd0;

  task automatic chk(input string name, input logic [15:0] tag,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s tag=%0d actual=%h expected=%h", name, tag, act, exp);
    end
  endtask

  // Monitor: pops one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("fwd_sel", e.tag, 64'(fwd_sel), 64'(e.sel));
      chk("op_out", e.tag, 64'(op_out), 64'(e.op));
      chk("stall", e.tag, 64'(stall), 64'(e.stall));
      chk("flush_ex", e.tag, 64'(flush_ex), 64'(e.stall));
      chk("md_busy", e.tag, 64'(md_busy), 64'(e.busy));
      chk("md_done", e.tag, 64'(md_done), 64'(e.done));
`ifdef STALL_CNT_EN
      chk("stall_count", e.tag, 64'(stall_count), 64'(e.cnt));
`endif
    end
  end

  // Expected select for one EX source, straight from the priority rules.
  function automatic logic [1:0] ref_sel(input int i);
    logic [AW-1:0] s;
    s = ex_src_addr[i*AW +: AW];
    if (s == 0) return 2'd0;
    if (mem_regwrite && mem_rd == s) return mem_memread ? 2'd3 : 2'd1;
    if (wb_regwrite && wb_rd == s) return 2'd2;
    return 2'd0;
  endfunction

  // Driver step: model the current inputs, queue the expectation, advance one clock.
  task automatic step(input int tag);
    exp_t e;
    bit busy_now, done_now, lu, mh;
    busy_now = (md_start_cyc >= 0) && (cyc > md_start_cyc) && (cyc < md_start_cyc + ML);
    done_now = (md_start_cyc >= 0) && (cyc == md_start_cyc + ML);
    lu = 1'b0;
    for (int i = 0; i < NS; i++) begin
      logic [1:0] s;
      s = ref_sel(i);
      e.sel[i*2 +: 2] = s;
      e.op[i*DW +: DW] = (s == 2'd0) ? reg_data[i*DW +: DW] :
                         (s == 2'd1) ? exmem_alu :
                         (s == 2'd2) ? memwb_res : mem_dout;
      if (ex_memread && ex_rd != 0 && id_src_use[i] && id_src_addr[i*AW +: AW] == ex_rd)
        lu = 1'b1;
    end
    mh = id_md_use && (busy_now || md_start);
    e.stall = !rst && (lu || mh);
    e.busy = busy_now;
    e.done = done_now;
    e.cnt = m_cnt;
    e.tag = 16'(tag);
    exp_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      md_start_cyc = -1;
      m_cnt = 32'd0;
    end else begin
      if (e.stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (md_start && !busy_now) md_start_cyc = cyc;
    end
    cyc++;
    #1;
  endtask

  task automatic clear_inputs();
    rst = 1'b0;
    id_src_addr = '0; id_src_use = '0; id_md_use = 1'b0;
    ex_src_addr = '0; ex_rd = '0; ex_memread = 1'b0;
    mem_rd = '0; mem_regwrite = 1'b0; mem_memread = 1'b0;
    wb_rd = '0; wb_regwrite = 1'b0;
    reg_data = {32'h0BAD_0001, 32'h0BAD_0000};
    exmem_alu = 32'h1111_1111; memwb_res = 32'h2222_2222; mem_dout = 32'h3333_3333;
    md_start = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    step(1);                       // reset state
    step(2);
    rst = 1'b0;

    // EX/MEM ALU forward
    mem_rd = 5'd8; mem_regwrite = 1'b1; ex_src_addr[0 +: AW] = 5'd8; exmem_alu = 32'h1234;
    step(10);
    // EX/MEM beats MEM/WB
    clear_inputs();
    mem_rd = 5'd9; wb_rd = 5'd9; mem_regwrite = 1'b1; wb_regwrite = 1'b1;
    ex_src_addr[AW +: AW] = 5'd9;
    step(11);
    // MEM/WB only
    mem_regwrite = 1'b0;
    step(12);
    // register 0 guard
    clear_inputs();
    mem_rd = 5'd0; mem_regwrite = 1'b1; ex_src_addr[0 +: AW] = 5'd0; reg_data[0 +: DW] = 32'd0;
    step(13);

    // Load-use: one stall, then the load sits in MEM and takes select 3
    clear_inputs();
    ex_memread = 1'b1; ex_rd = 5'd5; id_src_addr[0 +: AW] = 5'd5; id_src_use = 2'b01;
    step(20);
    ex_memread = 1'b0; ex_rd = 5'd0;
    mem_memread = 1'b1; mem_regwrite = 1'b1; mem_rd = 5'd5; mem_dout = 32'hCAFE;
    ex_src_addr[0 +: AW] = 5'd5;
    step(21);
    // load into r0 never stalls
    clear_inputs();
    ex_memread = 1'b1; ex_rd = 5'd0; id_src_use = 2'b11;
    step(22);

    // Mult/div: start at cycle 0, HI/LO reader held, second start at cycle 2 ignored
    clear_inputs();
    id_md_use = 1'b1;
    for (int c = 0; c < 7; c++) begin
      md_start = (c == 0 || c == 2);
      step(30 + c);
    end
    // Back-to-back: restart on the DONE cycle
    for (int c = 0; c < 10; c++) begin
      md_start = (c == 0 || c == ML);
      step(40 + c);
    end

    // Reset mid-BUSY abandons the op
    for (int c = 0; c < 8; c++) begin
      md_start = (c == 0);
      rst = (c == 2);
      step(60 + c);
    end

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < NS; i++) begin
        id_src_addr[i*AW +: AW] = AW'($urandom_range(0, 3));
        ex_src_addr[i*AW +: AW] = AW'($urandom_range(0, 3));
        reg_data[i*DW +: DW] = $urandom;
      end
      id_src_use = NS'($urandom_range(0, 3));
      id_md_use = 1'($urandom_range(0, 1));
      ex_rd = AW'($urandom_range(0, 3)); ex_memread = 1'($urandom_range(0, 1));
      mem_rd = AW'($urandom_range(0, 3)); mem_regwrite = 1'($urandom_range(0, 1));
      mem_memread = 1'($urandom_range(0, 1));
      wb_rd = AW'($urandom_range(0, 3)); wb_regwrite = 1'($urandom_range(0, 1));
      exmem_alu = $urandom; memwb_res = $urandom; mem_dout = $urandom;
      md_start = ($urandom_range(0, 5) == 0);
      step(1000 + n);
    end

    clear_inputs();
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0 pending", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
